// File: rtl/shift_cmd_queue_pkg.sv
// Shared definitions for the shift command queue:
// op encodings and the command bundle.
package shift_cmd_queue_pkg;

    localparam logic [1:0] OP_LEFT_LOGICAL  = 2'b00;
    localparam logic [1:0] OP_RIGHT_LOGICAL = 2'b10;
    localparam logic [1:0] OP_RIGHT_ARITH   = 2'b11;
    localparam logic [1:0] OP_PASSTHRU      = 2'b01;

    localparam int CMD_DATA_W = 8;
    localparam int CMD_SA_W   = $clog2(CMD_DATA_W);

    typedef struct packed {
        logic [CMD_DATA_W-1:0] data;
        logic                  right;
        logic                  arith;
        logic [CMD_SA_W-1:0]   sa;
    } cmd_t;

endpackage

// File: rtl/shift_cmd_queue_shifter.sv
// Combinational barrel shifter: logical left/right,
// arithmetic right, and pass-through on the unused encoding.
module barrel_shifter
    import shift_cmd_queue_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int SA_W        = $clog2(DATA_LENGTH)
) (
    input  logic [DATA_LENGTH-1:0] data,
    input  logic                   right,
    input  logic                   arith,
    input  logic [SA_W-1:0]        sa,
    output logic [DATA_LENGTH-1:0] result
);

    always_comb begin
        result = data;
        unique case ({right, arith})
            OP_LEFT_LOGICAL:  result = data << sa;
            OP_RIGHT_LOGICAL: result = data >> sa;
            OP_RIGHT_ARITH:   result = $signed(data) >>> sa;
            OP_PASSTHRU:      result = data;
        endcase
    end

endmodule

// File: rtl/shift_cmd_queue.sv
// Buffered shift command front-end: FIFO of commands,
// one shifter on the head, registered result stage.
module shift_cmd_queue
    import shift_cmd_queue_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int DEPTH       = 4,
    parameter int SA_W        = $clog2(DATA_LENGTH),
    parameter int PW          = $clog2(DEPTH),
    parameter int CW          = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_LENGTH-1:0] in_data,
    input  logic                   in_right,
    input  logic                   in_arith,
    input  logic [SA_W-1:0]        in_sa,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LENGTH-1:0] out_data,
    output logic                   out_passthru,
    output logic [CW-1:0]          level
);

    typedef struct packed {
        logic [DATA_LENGTH-1:0] data;
        logic                   right;
        logic                   arith;
        logic [SA_W-1:0]        sa;
    } entry_t;

    entry_t                 mem [DEPTH];
    logic   [PW-1:0]        wr_ptr;
    logic   [PW-1:0]        rd_ptr;
    logic   [CW-1:0]        count;
    entry_t                 head;
    logic   [DATA_LENGTH-1:0] shifted;
    logic                   push;
    logic                   load_en;

    assign in_ready = rst_n && (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign load_en  = (count != '0) && (!out_valid || out_ready);
    assign head     = mem[rd_ptr];
    assign level    = count;

    barrel_shifter #(
        .DATA_LENGTH(DATA_LENGTH),
        .SA_W       (SA_W)
    ) u_shifter (
        .data  (head.data),
        .right (head.right),
        .arith (head.arith),
        .sa    (head.sa),
        .result(shifted)
    );

    // Storage needs no reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: in_data, right: in_right,
                             arith: in_arith, sa: in_sa};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (load_en)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, load_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_passthru <= 1'b0;
        end else if (load_en) begin
            out_valid    <= 1'b1;
            out_data     <= shifted;
            out_passthru <= ({head.right, head.arith} == OP_PASSTHRU);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue: expected results queued
// on input handshake, compared on output handshake.
module tb_shift_cmd_queue;
    import shift_cmd_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_right;
    logic       in_arith;
    logic [2:0] in_sa;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_passthru;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    logic [8:0] sb [$];

    always #5 clk = ~clk;

    shift_cmd_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_right    (in_right),
        .in_arith    (in_arith),
        .in_sa       (in_sa),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_passthru(out_passthru),
        .level       (level)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bitwise reference model, {passthru, result}.
    function automatic logic [8:0] model(input cmd_t c);
        logic [7:0] r;
        int src;
        r = c.data;
        case ({c.right, c.arith})
            2'b00: for (int i = 0; i < 8; i++) begin
                src = i - int'(c.sa);
                r[i] = (src >= 0) ? c.data[src] : 1'b0;
            end
            2'b10: for (int i = 0; i < 8; i++) begin
                src = i + int'(c.sa);
                r[i] = (src < 8) ? c.data[src] : 1'b0;
            end
            2'b11: for (int i = 0; i < 8; i++) begin
                src = i + int'(c.sa);
                r[i] = (src < 8) ? c.data[src] : c.data[7];
            end
            default: r = c.data;
        endcase
        return {({c.right, c.arith} == 2'b01), r};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", {24'd0, out_data}, 32'hdead);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    chk("out_passthru", {31'd0, out_passthru},
                        {31'd0, e[8]});
                end
            end
            if (in_valid && in_ready) begin
                cmd_t c;
                c = '{data: in_data, right: in_right,
                      arith: in_arith, sa: in_sa};
                sb.push_back(model(c));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic r,
                        input logic a, input logic [2:0] s);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_right = r;
        in_arith = a;
        in_sa    = s;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_right  = 1'b0;
        in_arith  = 1'b0;
        in_sa     = 3'd1;
        out_ready = 1'b1;
        tick(3);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick(3);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_level", {29'd0, level}, 32'd0);

        send(8'h81, 1'b0, 1'b0, 3'd1);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {24'd0, out_data}, 32'h02);
        chk("lat_passthru", {31'd0, out_passthru}, 32'd0);
        tick(2);

        send(8'h90, 1'b1, 1'b1, 3'd3);
        send(8'h90, 1'b1, 1'b0, 3'd3);
        tick(3);

        out_ready = 1'b0;
        send(8'h11, 1'b0, 1'b0, 3'd2);
        send(8'hC3, 1'b1, 1'b1, 3'd5);
        send(8'h3C, 1'b1, 1'b0, 3'd4);
        send(8'hA5, 1'b0, 1'b1, 3'd6);
        send(8'h7E, 1'b0, 1'b0, 3'd7);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_level", {29'd0, level}, 32'd4);
        chk("bp_hold0", {24'd0, out_data}, 32'h44);
        tick(3);
        chk("bp_hold1", {24'd0, out_data}, 32'h44);
        chk("bp_level_hold", {29'd0, level}, 32'd4);
        base = n_out;
        out_ready = 1'b1;
        tick(5);
        chk("bp_drain_count", n_out - base, 32'd5);
        chk("bp_drain_level", {29'd0, level}, 32'd0);
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

        send(8'h5A, 1'b0, 1'b1, 3'd7);
        tick(1);
        chk("pt_data", {24'd0, out_data}, 32'h5A);
        chk("pt_flag", {31'd0, out_passthru}, 32'd1);
        tick(2);

        out_ready = 1'b0;
        send(8'h01, 1'b0, 1'b0, 3'd1);
        send(8'h02, 1'b1, 1'b0, 3'd1);
        send(8'h83, 1'b1, 1'b1, 3'd1);
        chk("st_level_pre", {29'd0, level}, 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            base = n_out;
            send(8'(8'h40 + i * 8'h13), 1'(i), 1'(i >> 1), 3'(i));
            chk("st_level", {29'd0, level}, 32'd2);
            chk("st_rate", n_out - base, 32'd1);
        end
        out_ready = 1'b0;
        send(8'hEE, 1'b1, 1'b1, 3'd2);
        chk("pre_rst_level", {29'd0, level}, 32'd3);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sb.delete();
        tick(1);
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        in_valid  = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(10);
        chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_cmd_queue.md
Name: shift_cmd_queue

Overview:
- Buffered command front-end for the combinational barrel_shifter datapath.
- Accepts shift commands (operand, direction, mode, amount) over a valid/ready interface into a DEPTH-entry FIFO.
- Applies the head command through one barrel_shifter instance and holds the result in a registered output stage with valid/ready back-pressure.
- Sits between an upstream command producer and any downstream result consumer; sustains one command per cycle.

Parameters:
- DATA_LENGTH, 8: operand/result width; shift amount width is $clog2(DATA_LENGTH).
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream command valid.
- in_ready  output  1  queue can accept a command this cycle.
- in_data  input  DATA_LENGTH  signed operand.
- in_right  input  1  1 = shift right, 0 = shift left.
- in_arith  input  1  1 = arithmetic, 0 = logical.
- in_sa  input  $clog2(DATA_LENGTH)  shift amount, 0..DATA_LENGTH-1.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_LENGTH  shifted result.
- out_passthru  output  1  result came from the undefined {right=0, arith=1} encoding.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH; excludes the output register.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Read/write pointers and count go to 0.
  - out_valid=0, out_data=0, out_passthru=0, level=0.
  - in_ready is forced 0 combinationally while rst_n is low, so no command is accepted during reset.
  - Reset mid-operation discards all queued commands and any held result on that edge.
- Push: occurs when in_valid && in_ready. The command {in_data, in_right, in_arith, in_sa} is written at the write pointer, and the write pointer increments modulo DEPTH.
- in_ready = rst_n && (count < DEPTH). It does not depend on out_ready, so there is no same-cycle push-through when full.
- Output-stage load condition: load_en = (count != 0) && (!out_valid || out_ready).
- On load_en:
  - The head entry drives barrel_shifter combinationally.
  - The result is registered into out_data, out_passthru is set iff the head op is {0,1}, and out_valid goes to 1.
  - The read pointer increments modulo DEPTH.
- If out_valid && out_ready && count==0, out_valid goes to 0; out_data holds its last value.
- While out_valid && !out_ready: out_data and out_passthru hold stable and the FIFO does not pop.
- Operation per {right, arith}:
  - 00: logical left; zeros shifted in.
  - 10: logical right; zeros shifted in.
  - 11: arithmetic right; sign bit replicated.
  - 01: operand passed unchanged, and out_passthru=1.
- Count update: push only gives +1, pop only gives -1, simultaneous push and pop leaves it unchanged. level mirrors count as a registered value.
- Latency: a command accepted at edge N, into an empty queue with an idle output, produces out_valid=1 after edge N+1 (2 cycles from in_valid to out_valid).
- Throughput: 1 result per cycle when out_ready is held high.
- Ordering: results are strictly FIFO order; no loss or duplication.
- Pointer wrap: pointers roll from DEPTH-1 to 0; full and empty are distinguished by count, not by pointer equality.
- Total buffering: DEPTH + 1 commands (FIFO plus output register) before in_ready drops.

Decomposition:
- Shared package holds:
  - the op encoding localparams OP_LEFT_LOGICAL=2'b00, OP_RIGHT_LOGICAL=2'b10, OP_RIGHT_ARITH=2'b11, OP_PASSTHRU=2'b01;
  - a packed command struct typedef {data, right, arith, sa}.
- Sub-module: a single barrel_shifter instance, the existing combinational shifter, driven from the FIFO head.
- FIFO storage, pointers and the output register stay in this module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, level=0; after release, no stale command emerges.
- Left logical: in_data=8'h81, right=0, arith=0, sa=1, in cycle k -> out_valid=1 in cycle k+2, out_data=8'h02, out_passthru=0.
- Right modes: 8'h90 with right=1, arith=1, sa=3 -> 8'hF2; then 8'h90 with right=1, arith=0, sa=3 -> 8'h12, in order on back-to-back cycles.
- Back-pressure (out_ready=0): push 5 distinct commands -> after 5 handshakes in_ready=0, level=4, out_data holds result 1 stable; raise out_ready -> results 1..5 on 5 consecutive cycles, level then 0, out_valid then 0.
- Passthrough: 8'h5A with right=0, arith=1, sa=7 -> out_data=8'h5A, out_passthru=1.
- Streaming and reset: continuous push with out_ready=1 at level 2 -> level stays 2, one result per cycle; assert rst_n=0 for 1 cycle at level 3 -> next edge gives level=0, out_valid=0, and the discarded commands never appear.
